// File: rtl/sort_seq_ctrl.sv
// In-place ascending unsigned bubble sort over the data-memory port.
// Define SORT_EARLY_EXIT_EN to finish as soon as a pass performs no swap.
module sort_seq_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [31:0]   count,
  output logic          busy,
  output logic          done,
  output logic [31:0]   swap_count,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_read,
  output logic          mem_write
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CMP, S_WR_A, S_WR_B, S_NEXT, S_DONE
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [31:0]   i_q, i_d;
  logic [31:0]   j_q, j_d;
  logic [31:0]   swap_q, swap_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
`ifdef SORT_EARLY_EXIT_EN
  logic          pass_swapped_q, pass_swapped_d;
`endif
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] addr_j_s, addr_j1_s;

  // Next-state and datapath update for the sort sequencer
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    i_d     = i_q;
    j_d     = j_q;
    swap_d  = swap_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef SORT_EARLY_EXIT_EN
    pass_swapped_d = pass_swapped_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_addr;
          swap_d = 32'd0;
          if (count >= 32'd2) begin
            i_d     = count - 32'd1;
            j_d     = 32'd0;
`ifdef SORT_EARLY_EXIT_EN
            pass_swapped_d = 1'b0;
`endif
            state_d = S_RD_A;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_A: begin
        a_d     = mem_rdata;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        b_d     = mem_rdata;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (a_q > b_q) begin
          state_d = S_WR_A;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WR_A: state_d = S_WR_B;
      S_WR_B: begin
        swap_d  = swap_q + 32'd1;
`ifdef SORT_EARLY_EXIT_EN
        pass_swapped_d = 1'b1;
`endif
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (j_q < i_q - 32'd1) begin
          j_d     = j_q + 32'd1;
          state_d = S_RD_A;
        end else if (i_q == 32'd1) begin
          state_d = S_DONE;
`ifdef SORT_EARLY_EXIT_EN
        end else if (!pass_swapped_q) begin
          state_d = S_DONE;
`endif
        end else begin
          i_d     = i_q - 32'd1;
          j_d     = 32'd0;
`ifdef SORT_EARLY_EXIT_EN
          pass_swapped_d = 1'b0;
`endif
          state_d = S_RD_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered
  always_comb begin
    addr_j_s  = base_d + AW'(j_d);
    addr_j1_s = addr_j_s + ADDR_ONE;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    addr_d    = {AW{1'b0}};
    wdata_d   = {DW{1'b0}};
    case (state_d)
      S_RD_A: begin
        rd_d   = 1'b1;
        addr_d = addr_j_s;
      end
      S_RD_B: begin
        rd_d   = 1'b1;
        addr_d = addr_j1_s;
      end
      S_WR_A: begin
        wr_d    = 1'b1;
        addr_d  = addr_j_s;
        wdata_d = b_d;
      end
      S_WR_B: begin
        wr_d    = 1'b1;
        addr_d  = addr_j1_s;
        wdata_d = a_d;
      end
      default: begin
        rd_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= {AW{1'b0}};
      i_q     <= 32'd0;
      j_q     <= 32'd0;
      swap_q  <= 32'd0;
      a_q     <= {DW{1'b0}};
      b_q     <= {DW{1'b0}};
`ifdef SORT_EARLY_EXIT_EN
      pass_swapped_q <= 1'b0;
`endif
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= {AW{1'b0}};
      wdata_q <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      i_q     <= i_d;
      j_q     <= j_d;
      swap_q  <= swap_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef SORT_EARLY_EXIT_EN
      pass_swapped_q <= pass_swapped_d;
`endif
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign swap_count = swap_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Randomized self-checking bench for sort_seq_ctrl; expected results come from
// a sorted-copy / inversion-count model. Honours SORT_EARLY_EXIT_EN when defined.
module tb_sort_seq_ctrl;

`ifdef SORT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] base_addr, count;
  logic        busy, done, mem_read, mem_write;
  logic [31:0] swap_count, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  logic        tb_we;
  logic [7:0]  tb_wa;
  logic [31:0] tb_wd;

  int n_checks = 0, n_fail = 0;
  int n_rd = 0, n_wr = 0, n_done = 0, n_both = 0, n_hi = 0, n_idlebus = 0;

  int unsigned cur_q[$], exp_q[$];
  int exp_swaps, exp_cyc;

  always #5 clk = ~clk;

  sort_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .swap_count(swap_count), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_read(mem_read),
    .mem_write(mem_write)
  );

  // 256-word memory aliased on the low address byte
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end
  assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : 32'd0;

  // bus activity monitor
  always @(negedge clk) begin
    if (mem_read) n_rd <= n_rd + 1;
    if (mem_write) n_wr <= n_wr + 1;
    if (done) n_done <= n_done + 1;
    if (mem_read && mem_write) n_both <= n_both + 1;
    if ((mem_read || mem_write) && mem_addr == 32'hFFFF_FFFF) n_hi <= n_hi + 1;
    if (!mem_read && !mem_write && (mem_addr !== 32'd0 || mem_wdata !== 32'd0))
      n_idlebus <= n_idlebus + 1;
  end

  task automatic load_vals(input logic [31:0] b);
    for (int k = 0; k < cur_q.size(); k++) begin
      tb_we = 1'b1; tb_wa = 8'(b + k); tb_wd = cur_q[k];
      @(posedge clk); #1;
    end
    tb_we = 1'b0;
  endtask

  // sorted copy, inversion count = swaps, pass count from max left-inversions
  task automatic compute_model();
    int n, lmax, inv, passes, cmps;
    exp_q = cur_q;
    exp_q.sort();
    n = cur_q.size();
    exp_swaps = 0; lmax = 0;
    for (int k = 0; k < n; k++) begin
      inv = 0;
      for (int p = 0; p < k; p++) if (cur_q[p] > cur_q[k]) inv++;
      exp_swaps += inv;
      if (inv > lmax) lmax = inv;
    end
    cmps = 0;
    if (n >= 2) begin
      passes = n - 1;
      if (EARLY && (lmax + 1 < passes)) passes = lmax + 1;
      for (int p = 1; p <= passes; p++) cmps += n - p;
    end
    exp_cyc = 4 * cmps + 2 * exp_swaps + 1;
  endtask

  task automatic run_sort(input logic [31:0] b, input logic [31:0] n,
                          input int hold, output int cyc);
    base_addr = b; count = n; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    if (hold == 0) start = 1'b0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > hold) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({busy, done, mem_read, mem_write} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, mem_read, mem_write}); end
    n_checks++; if (swap_count !== 32'd0) begin n_fail++;
      $display("FAIL reset_swap: got %0d expected 0", swap_count); end
    n_checks++; if (mem_addr !== 32'd0) begin n_fail++;
      $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'd0) begin n_fail++;
      $display("FAIL reset_wdata: got %0h expected 0", mem_wdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_spec_example();
    int cyc, d0;
    cur_q = '{25, 17, 20, 78, 10, 63, 100, 39, 113, 13};
    load_vals(32'd0); compute_model();
    d0 = n_done;
    run_sort(32'd0, 32'd10, 0, cyc);
    n_checks++; if (cyc != exp_cyc) begin n_fail++;
      $display("FAIL ex_done_cycle: got %0d expected %0d", cyc, exp_cyc); end
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (mem[k] !== exp_q[k]) begin n_fail++;
        $display("FAIL ex_mem[%0d]: got %0d expected %0d", k, mem[k], exp_q[k]); end
    end
    n_checks++; if (swap_count !== 32'd18) begin n_fail++;
      $display("FAIL ex_swaps: got %0d expected 18", swap_count); end
    n_checks++; if (n_done - d0 != 1 || done !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL ex_done_pulse: got %0d pulses done=%b busy=%b expected 1,0,0",
               n_done - d0, done, busy); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (swap_count !== 32'd18) begin n_fail++;
      $display("FAIL ex_swap_hold: got %0d expected 18", swap_count); end
  endtask

  task automatic test_sorted();
    int cyc, w0, want;
    cur_q = '{1, 2, 3, 4};
    load_vals(32'd20);
    want = EARLY ? 13 : 25;
    w0 = n_wr;
    run_sort(32'd20, 32'd4, 0, cyc);
    n_checks++; if (cyc != want) begin n_fail++;
      $display("FAIL sorted_done_cycle: got %0d expected %0d", cyc, want); end
    @(posedge clk); #1;
    n_checks++; if (swap_count !== 32'd0 || n_wr != w0) begin n_fail++;
      $display("FAIL sorted_no_write: got swaps %0d writes %0d expected 0,0",
               swap_count, n_wr - w0); end
  endtask

  task automatic test_short();
    int cyc, r0, w0;
    cur_q = '{77};
    load_vals(32'd40);
    for (int c = 1; c >= 0; c--) begin
      r0 = n_rd; w0 = n_wr;
      run_sort(32'd40, 32'(c), 0, cyc);
      n_checks++; if (cyc != 1 || busy !== 1'b1) begin n_fail++;
        $display("FAIL short%0d_done: got cycle %0d busy %b expected 1,1", c, cyc, busy); end
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0 || n_rd != r0 || n_wr != w0 || mem[40] !== 32'd77) begin
        n_fail++;
        $display("FAIL short%0d_quiet: got busy %b rd %0d wr %0d m %0d expected 0,0,0,77",
                 c, busy, n_rd - r0, n_wr - w0, mem[40]); end
    end
  endtask

  task automatic test_dup_hold();
    int cyc, d0;
    cur_q = '{5, 5, 3};
    load_vals(32'd100); compute_model();
    d0 = n_done;
    run_sort(32'd100, 32'd3, 6, cyc);
    n_checks++; if (cyc != exp_cyc) begin n_fail++;
      $display("FAIL dup_done_cycle: got %0d expected %0d", cyc, exp_cyc); end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (mem[100 + k] !== exp_q[k]) begin n_fail++;
        $display("FAIL dup_mem[%0d]: got %0d expected %0d", k, mem[100 + k], exp_q[k]); end
    end
    n_checks++; if (swap_count !== 32'd2 || n_done - d0 != 1) begin n_fail++;
      $display("FAIL dup_swaps: got %0d pulses %0d expected 2,1", swap_count, n_done - d0); end
  endtask

  task automatic test_reset_mid();
    int cyc, r0, w0;
    cur_q = '{25, 17, 20, 78, 10, 63, 100, 39, 113, 13};
    load_vals(32'd0); compute_model();
    base_addr = 32'd0; count = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({busy, done, mem_read, mem_write} !== 4'b0 || swap_count !== 32'd0 ||
                    mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin n_fail++;
      $display("FAIL midreset_outputs: got %b swap %0d addr %0h wdata %0h expected all 0",
               {busy, done, mem_read, mem_write}, swap_count, mem_addr, mem_wdata); end
    r0 = n_rd; w0 = n_wr;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (n_rd != r0 || n_wr != w0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL midreset_quiet: got rd %0d wr %0d busy %b expected 0,0,0",
               n_rd - r0, n_wr - w0, busy); end
    load_vals(32'd0);
    run_sort(32'd0, 32'd10, 0, cyc);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (mem[k] !== exp_q[k]) begin n_fail++;
        $display("FAIL resort_mem[%0d]: got %0d expected %0d", k, mem[k], exp_q[k]); end
    end
    n_checks++; if (swap_count !== 32'(exp_swaps) || cyc != exp_cyc) begin n_fail++;
      $display("FAIL resort_swaps: got %0d cyc %0d expected %0d cyc %0d",
               swap_count, cyc, exp_swaps, exp_cyc); end
  endtask

  task automatic test_wrap();
    int cyc, h0;
    cur_q = '{9, 4};
    load_vals(32'hFFFF_FFFF);
    h0 = n_hi;
    run_sort(32'hFFFF_FFFF, 32'd2, 0, cyc);
    @(posedge clk); #1;
    n_checks++; if (mem[255] !== 32'd4 || mem[0] !== 32'd9) begin n_fail++;
      $display("FAIL wrap_mem: got %0d,%0d expected 4,9", mem[255], mem[0]); end
    n_checks++; if (swap_count !== 32'd1 || cyc != 7 || n_hi - h0 != 2) begin n_fail++;
      $display("FAIL wrap_ctrl: got swaps %0d cyc %0d hi %0d expected 1,7,2",
               swap_count, cyc, n_hi - h0); end
  endtask

  task automatic test_random();
    int cyc, n;
    logic [31:0] b;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(12, 2);
      b = 32'($urandom_range(200, 0));
      cur_q.delete();
      for (int k = 0; k < n; k++)
        cur_q.push_back((it % 2 == 0) ? $urandom_range(7, 0) : $urandom);
      load_vals(b); compute_model();
      run_sort(b, 32'(n), 0, cyc);
      @(posedge clk); #1;
      for (int k = 0; k < n; k++) begin
        n_checks++; if (mem[8'(b + k)] !== exp_q[k]) begin n_fail++;
          $display("FAIL rnd%0d_mem[%0d]: got %0h expected %0h", it, k, mem[8'(b + k)], exp_q[k]); end
      end
      n_checks++; if (swap_count !== 32'(exp_swaps) || cyc != exp_cyc) begin n_fail++;
        $display("FAIL rnd%0d_ctrl: got swaps %0d cyc %0d expected %0d cyc %0d",
                 it, swap_count, cyc, exp_swaps, exp_cyc); end
    end
  endtask

  task automatic test_bus_rules();
    n_checks++; if (n_both != 0) begin n_fail++;
      $display("FAIL bus_rd_wr_overlap: got %0d cycles expected 0", n_both); end
    n_checks++; if (n_idlebus != 0) begin n_fail++;
      $display("FAIL bus_idle_nonzero: got %0d cycles expected 0", n_idlebus); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 32'd0; count = 32'd0;
    tb_we = 1'b0; tb_wa = 8'd0; tb_wd = 32'd0;
    test_reset();
    test_spec_example();
    test_sorted();
    test_short();
    test_dup_hold();
    test_reset_mid();
    test_wrap();
    test_random();
    test_bus_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sort_seq_ctrl.md
# sort_seq_ctrl

Hardware bubble-sort sequencer that owns the data-memory port and sorts a contiguous block of 32-bit words in place, in ascending unsigned order. It sits beside the core on the data-memory address/write-data/read-data/memwrite/memread bus and drives that bus only while busy. Software or the testbench supplies a base address and element count and pulses start. The block reports completion and the number of swaps performed.

## Interface
- AW, 32, address width; all address arithmetic is modulo 2^AW
- DW, 32, data word width

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  start request; sampled only in IDLE
- base_addr  in  AW  word address of element 0; latched on accepted start
- count  in  32  number of elements; latched on accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse in DONE state
- swap_count  out  32  swaps performed by the current or last sort
- mem_addr  out  AW  data-memory word address
- mem_wdata  out  DW  data-memory write data
- mem_rdata  in  DW  data-memory read data; combinational from mem_addr while mem_read=1
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe; the word is written at the clock edge ending the cycle

## Operation
- Algorithm: for i = N-1 down to 1, for j = 0 .. i-1:
  - A = M[base+j], B = M[base+j+1]
  - if A > B (unsigned): M[base+j] = B, M[base+j+1] = A
- Equal elements are never swapped.
- States and transitions:
  - IDLE: start=1 and N>=2 -> RD_A; start=1 and N<2 -> DONE with no memory access; otherwise stay.
  - RD_A: mem_read=1, mem_addr=base+j; capture A at edge -> RD_B.
  - RD_B: mem_read=1, mem_addr=base+j+1; capture B at edge -> CMP.
  - CMP: no memory access; A>B -> WR_A, else -> NEXT.
  - WR_A: mem_write=1, addr base+j, wdata B -> WR_B.
  - WR_B: mem_write=1, addr base+j+1, wdata A; swap_count++ and pass_swapped=1 -> NEXT.
  - NEXT: if j<i-1, then j++ -> RD_A. Otherwise the pass ends: if i==1 -> DONE; else i--, j=0, pass_swapped=0 -> RD_A.
  - DONE: done=1 -> IDLE.
- mem_read and mem_write are never high together. Both are 0 outside the RD_* and WR_* states, where mem_addr=0 and mem_wdata=0.
- start is ignored while busy. base_addr and count are not re-sampled mid-sort.
- swap_count clears to 0 on accepted start and holds its value after DONE until the next accepted start.
- base+j+1 wraps modulo 2^AW.

## Timing
- Reset values: state IDLE; busy=0, done=0, swap_count=0, mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0.
- Reset asserted mid-sort returns the block to IDLE on that edge. Memory is left partially sorted; no further accesses occur.
- Per compare: 4 cycles without a swap (RD_A, RD_B, CMP, NEXT), 6 cycles with a swap.
- Start is accepted at edge E0. The first RD_A is the cycle after E0. done is high for exactly one cycle, immediately after the final NEXT.
- N<2: DONE is the cycle after E0 and busy is high for 1 cycle.
- A start on the same edge that DONE returns to IDLE is not accepted. Start is accepted on the following edge at the earliest.

## Configuration
- SORT_EARLY_EXIT_EN defined:
  - At the end of a pass with pass_swapped=0, NEXT -> DONE even if i>1.
  - An already-sorted block finishes after one pass of N-1 compares.
- SORT_EARLY_EXIT_EN undefined:
  - All N-1 passes always execute, giving N(N-1)/2 compares.
  - pass_swapped is not implemented.

## Test plan
- M[0..9] = 25,17,20,78,10,63,100,39,113,13, base=0, count=10, start -> M = 10,13,17,20,25,39,63,78,100,113; swap_count=18; single done pulse.
- M[0..3] = 1,2,3,4, count=4 -> with EARLY_EXIT, done in cycle 13 after E0; without it, done in cycle 25; swap_count=0; mem_write never asserted.
- count=1 and count=0 -> done in cycle 1 after E0; no mem_read/mem_write; memory unchanged.
- Duplicates 5,5,3 at base=100 -> 3,5,5; swap_count=2. A start pulse held during busy does not restart the sort.
- Reset 20 cycles into the 10-element sort -> next cycle busy=0, all outputs 0; a new start then sorts correctly and swap_count restarts from 0.
- base=2^AW-1, count=2, M[2^AW-1]=9, M[0]=4 -> wrapped addresses are used; M[2^AW-1]=4, M[0]=9; swap_count=1.
